cdb_arbiter: RTL



---
 rtl/gpu_cdb_pkg.sv | 25 ++
 rtl/cdb_mult_fifo.sv | 61 ++++++
 rtl/cdb_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/gpu_cdb_pkg.sv
// Shared types and constants for the common data bus (CDB) arbitration logic.
package gpu_cdb_pkg;

  localparam int CDB_INSTR_W     = 32;
  localparam int CDB_WARP_W      = 3;
  localparam int CDB_DST_W       = 5;
  localparam int CDB_DATA_WIDTH  = 32;
  localparam int CDB_NUM_THREADS = 8;
  localparam int CDB_LANES_W     = CDB_DATA_WIDTH * CDB_NUM_THREADS;

  // Which execution unit produced the broadcast result.
  typedef enum logic {
    SRC_ALU  = 1'b0,
    SRC_MULT = 1'b1
  } cdb_src_e;

  // One writeback beat: instruction tag, warp, destination register and all lane data.
  typedef struct packed {
    logic [CDB_INSTR_W-1:0] instr;
    logic [CDB_WARP_W-1:0]  warp;
    logic [CDB_DST_W-1:0]   dst;
    logic [CDB_LANES_W-1:0] data;
  } cdb_payload_t;

endpackage

// File: rtl/cdb_mult_fifo.sv
// Small synchronous FIFO holding MULT results that lost CDB arbitration.
// Pointers wrap at DEPTH, so any DEPTH >= 1 works (not just powers of two).
module cdb_mult_fifo
  import gpu_cdb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  cdb_payload_t                 wdata,
  input  logic                         pop,
  output cdb_payload_t                 rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  cdb_payload_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             push_en;
  logic             pop_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign count   = count_q;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_en) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_en)  rd_ptr <= ptr_inc(rd_ptr);
      if (push_en && !pop_en)      count_q <= count_q + 1'b1;
      else if (!push_en && pop_en) count_q <= count_q - 1'b1;
    end
  end

  // Storage write; entries are only read when count says they are valid.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; emptiness is tracked by count, which is reset.
    if (push_en) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Arbitrates the single CDB between the ALU (never back-pressured, always wins)
// and the MULT unit (queued, drained in idle slots). A starvation counter
// stalls OC issue so queued MULT results are guaranteed to drain.
module cdb_arbiter
  import gpu_cdb_pkg::*;
#(
  parameter int DATA_WIDTH      = CDB_DATA_WIDTH,
  parameter int NUM_THREADS     = CDB_NUM_THREADS,
  parameter int MULT_FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              Valid_ALU_CDB,
  input  logic [CDB_INSTR_W-1:0]            Instr_ALU_CDB,
  input  logic [CDB_WARP_W-1:0]             WarpID_ALU_CDB,
  input  logic [CDB_DST_W-1:0]              Dst_ALU_CDB,
  input  logic [NUM_THREADS*DATA_WIDTH-1:0] Dst_Data_ALU_CDB,
  input  logic                              Valid_MULT_CDB,
  input  logic [CDB_INSTR_W-1:0]            Instr_MULT_CDB,
  input  logic [CDB_WARP_W-1:0]             WarpID_MULT_CDB,
  input  logic [CDB_DST_W-1:0]              Dst_MULT_CDB,
  input  logic [NUM_THREADS*DATA_WIDTH-1:0] Dst_Data_MULT_CDB,
  output logic                              Ready_CDB_MULT,
  output logic                              Stall_CDB_OC,
  output logic                              Valid_CDB,
  output logic [CDB_INSTR_W-1:0]            Instr_CDB,
  output logic [CDB_WARP_W-1:0]             WarpID_CDB,
  output logic [CDB_DST_W-1:0]              Dst_CDB,
  output logic [NUM_THREADS*DATA_WIDTH-1:0] Data_CDB,
  output logic                              Src_CDB
);

  localparam int CNT_W    = $clog2(MULT_FIFO_DEPTH + 1);
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  cdb_payload_t        alu_pl;
  cdb_payload_t        mult_pl;
  cdb_payload_t        head_pl;
  cdb_payload_t        sel_pl;
  cdb_payload_t        cdb_q;
  cdb_src_e            sel_src;
  cdb_src_e            src_q;
  logic                sel_any;
  logic                valid_q;
  logic                mult_acc;
  logic                mult_byp;
  logic                fifo_push;
  logic                fifo_pop;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_empty;
  logic                fifo_full;
  logic [STARVE_W-1:0] starve_q;

  assign alu_pl  = '{instr: Instr_ALU_CDB,  warp: WarpID_ALU_CDB,
                     dst:   Dst_ALU_CDB,    data: Dst_Data_ALU_CDB};
  assign mult_pl = '{instr: Instr_MULT_CDB, warp: WarpID_MULT_CDB,
                     dst:   Dst_MULT_CDB,   data: Dst_Data_MULT_CDB};

  // Ready depends only on the registered occupancy, so there is no input-to-ready path.
  assign Ready_CDB_MULT = (fifo_count < CNT_W'(MULT_FIFO_DEPTH));
  assign mult_acc       = Valid_MULT_CDB && Ready_CDB_MULT;
  assign fifo_push      = mult_acc && !mult_byp && !fifo_full;

  cdb_mult_fifo #(
    .DEPTH (MULT_FIFO_DEPTH)
  ) u_mult_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (mult_pl),
    .pop   (fifo_pop),
    .rdata (head_pl),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Priority select: ALU, then queued MULT head, then MULT bypass when the queue is empty.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    sel_any  = 1'b1;
    sel_src  = SRC_ALU;
    sel_pl   = alu_pl;
    fifo_pop = 1'b0;
    mult_byp = 1'b0;
    if (Valid_ALU_CDB) begin
      sel_src = SRC_ALU;
    end else if (!fifo_empty) begin
      sel_src  = SRC_MULT;
      sel_pl   = head_pl;
      fifo_pop = 1'b1;
    end else if (mult_acc) begin
      sel_src  = SRC_MULT;
      sel_pl   = mult_pl;
      mult_byp = 1'b1;
    end else begin
      sel_any = 1'b0;
    end
  end

  // CDB output register; payload holds its last value while the bus is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      src_q   <= SRC_ALU;
      cdb_q   <= '0;
    end else begin
      valid_q <= sel_any;
      if (sel_any) begin
        src_q <= sel_src;
        cdb_q <= sel_pl;
      end
    end
  end

  // Starvation counter: counts unserved cycles of a non-empty queue, saturating at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (fifo_empty || fifo_pop) begin
      starve_q <= '0;
    end else if (starve_q != STARVE_W'(STARVE_LIMIT)) begin
      starve_q <= starve_q + 1'b1;
    end
  end

  assign Stall_CDB_OC = (starve_q == STARVE_W'(STARVE_LIMIT));
  assign Valid_CDB    = valid_q;
  assign Src_CDB      = src_q;
  assign Instr_CDB    = cdb_q.instr;
  assign WarpID_CDB   = cdb_q.warp;
  assign Dst_CDB      = cdb_q.dst;
  assign Data_CDB     = cdb_q.data;

endmodule
